// File: rtl/i2c_byte_writer.sv
// i2c_byte_writer: master-side I2C byte transmit stage.
// Shifts NBITS of data out MSB-first on SDA/SCL, releases SDA for one extra
// clock and samples the slave ACK. Every SCL period is four i_tick phases
// (LOW, HIGH1, HIGH2, HOLD); SDA only changes on entry to LOW.
//
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_tick          quarter-SCL-period strobe
//   i_start, i_data transfer request and byte (captured in IDLE only)
//   i_sda           synchronised SDA line (ACK sampling)
//   o_sda, o_scl    bus drive values (o_sda=1 means released)
//   o_busy, o_done  transfer in flight / one-cycle completion pulse
//   o_ack_err       NACK seen on the ACK clock; held until the next start
module i2c_byte_writer #(
  parameter int NBITS = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_start,
  input  logic [NBITS-1:0] i_data,
  input  logic             i_sda,
  output logic             o_sda,
  output logic             o_scl,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ack_err
);

  localparam int CW = $clog2(NBITS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOW   = 3'd1;
  localparam logic [2:0] S_HIGH1 = 3'd2;
  localparam logic [2:0] S_HIGH2 = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ack_err_q, ack_err_d;
  logic             ack_bit;

  // Count reaches NBITS only for the 9th (ACK) clock.
  assign ack_bit = (cnt_q == CW'(NBITS));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    ack_err_d = ack_err_q;
    case (state_q)
      S_IDLE: begin
        // A tick coinciding with the accepted start is deliberately ignored.
        if (i_start) begin
          shift_d   = i_data;
          cnt_d     = '0;
          ack_err_d = 1'b0;
          state_d   = S_LOW;
        end
      end
      S_LOW:   if (i_tick) state_d = S_HIGH1;
      S_HIGH1: if (i_tick) state_d = S_HIGH2;
      S_HIGH2: begin
        if (i_tick) begin
          // Sample late in the high phase so the slave has had a full half
          // period of SCL high to settle its ACK.
          if (ack_bit) ack_err_d = i_sda;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_tick) begin
          if (ack_bit) begin
            state_d = S_DONE;
          end else begin
            shift_d = {shift_q[NBITS-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
            state_d = S_LOW;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      ack_err_q <= ack_err_d;
    end
  end

  // Shift reg and count only move on the HOLD->LOW edge, so SDA is constant
  // for the whole LOW..HOLD window and never moves while SCL is high.
  always_comb begin
    o_scl = (state_q == S_HIGH1) || (state_q == S_HIGH2);
    case (state_q)
      S_LOW, S_HIGH1, S_HIGH2, S_HOLD: o_sda = ack_bit | shift_q[NBITS-1];
      default:                         o_sda = 1'b1;
    endcase
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = (state_q == S_DONE);
  assign o_ack_err = ack_err_q;

endmodule

// File: doc/i2c_byte_writer.md
Name: i2c_byte_writer

Overview:
- Master-side I2C byte transmit stage: serialises one 8-bit byte MSB-first onto SDA/SCL, then releases SDA for the 9th clock and samples the slave ACK.
- Sits between the START generator and the STOP generator. The bus controller starts it after START and checks o_ack_err before issuing the next byte or STOP.
- Uses the same quarter-period i_tick strobe as the start/stop generators, so all three share one timing source.

Parameters:
- NBITS, 8, data bits per transfer (ACK clock is extra); bit counter width is $clog2(NBITS+1).

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous, active-low reset
- i_tick  input  1  one-cycle quarter-SCL-period strobe
- i_start  input  1  request to send i_data; honoured only in IDLE
- i_data  input  NBITS  byte to send; captured on the accepted i_start
- i_sda  input  1  synchronised SDA line value (for ACK sampling)
- o_sda  output  1  SDA drive value (1 = released/high)
- o_scl  output  1  SCL drive value
- o_busy  output  1  high from the accepted start until DONE ends
- o_done  output  1  one-cycle completion pulse
- o_ack_err  output  1  1 = NACK sampled on the 9th clock

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, shift reg=0, bit count=0, o_ack_err=0. Outputs decode to o_scl=0, o_sda=1, o_busy=0, o_done=0. Reset mid-transfer aborts immediately with the same values.
- Outputs are decoded combinationally from state and shift-reg MSB. Everything else is registered on posedge i_clk.
- States: IDLE, LOW, HIGH1, HIGH2, HOLD, DONE.
- The phase states LOW→HIGH1→HIGH2→HOLD each advance only on i_tick, so one SCL period is 4 ticks.
- IDLE:
  - o_scl=0, o_sda=1.
  - On i_start: load shift reg←i_data, bit count←0, clear o_ack_err, go to LOW.
  - An i_tick in the same cycle as the accepted i_start is not counted.
- LOW: o_scl=0. o_sda=shift MSB for data bits; o_sda=1 for the ACK bit (bit count==NBITS).
- HIGH1 and HIGH2: o_scl=1, o_sda held at the LOW value. SDA never changes while SCL is high.
- ACK sampling: on the i_tick leaving HIGH2 with bit count==NBITS, o_ack_err←i_sda.
- HOLD: o_scl=0, o_sda held at the LOW value. On i_tick:
  - if bit count==NBITS, go to DONE;
  - else shift left by 1 with 0 fill, bit count+1, go to LOW.
- DONE:
  - o_busy=1, o_done=1, o_scl=0, o_sda=1; lasts exactly 1 cycle, then IDLE, independent of i_tick.
  - o_ack_err is valid during DONE and holds until the next accepted start.
- o_busy=1 in every state except IDLE.
- i_start while busy is ignored; i_data changes while busy have no effect.
- Latency: accepted start to o_done = 4*(NBITS+1) ticks + 1 cycle (36 ticks for NBITS=8).
- SCL ends low and SDA ends released, matching the STOP generator's entry condition.
- i_tick asserted continuously (tick every cycle) is legal: each phase lasts 1 cycle.

Test Plan:
- Reset mid-transfer: i_rst_n low during the 4th bit's HIGH1 → same cycle o_scl=0, o_sda=1, o_busy=0; after release, a new i_start is accepted normally.
- Send 0xA5 with i_sda=0 on the ACK clock, tick every 4 cycles:
  - SDA sampled at each SCL high reads 1,0,1,0,0,1,0,1, then 1 (released);
  - o_done pulses once at 36 ticks + 1 cycle;
  - o_ack_err=0.
- Send 0xFF with i_sda=1 during the ACK clock → o_ack_err=1 in the o_done cycle, held in IDLE; the next accepted start clears it to 0.
- Send 0x00 with i_tick tied high → o_scl toggles 0,1,1,0 per bit with no SDA edge while o_scl=1, and o_done at cycle 37 after start.
- Protocol checker (all runs): SDA never changes while o_scl=1 throughout any transfer.
- Send 0x3C; pulse i_start and change i_data to 0xFF mid-transfer → ignored; the transmitted bits stay 0,0,1,1,1,1,0,0; exactly one o_done.
